// File: rtl/hazard_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and control-bundle type for the hazard sequencer.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE      = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE      = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE      = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HAZ     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_m;
    logic bubble_ex;
    logic bubble_rb;
    logic flush_id;
  } ctrl_t;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-sequencer bundle: decode/EX fields in, stall/flush controls out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_ID;
  logic [31:0]      instr_EX;
  logic [4:0]       rs1_raddr_ID;
  logic [4:0]       rs2_raddr_ID;
  logic [4:0]       rd_waddr_EX;
  logic             branch_taken_ID;
  logic             dmem_busy_M;
  logic             stall_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             stall_M;
  logic             bubble_EX;
  logic             bubble_RB;
  logic             flush_ID;
  logic [CNT_W-1:0] stall_cycles;
  logic             wait_timeout;

  modport master (
    output instr_ID, instr_EX, rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX,
           branch_taken_ID, dmem_busy_M,
    input  stall_IF, stall_ID, stall_EX, stall_M, bubble_EX, bubble_RB,
           flush_ID, stall_cycles, wait_timeout
  );

  modport slave (
    input  instr_ID, instr_EX, rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX,
           branch_taken_ID, dmem_busy_M,
    output stall_IF, stall_ID, stall_EX, stall_M, bubble_EX, bubble_RB,
           flush_ID, stall_cycles, wait_timeout
  );
endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// Combinational detection of hazards the forwarding network cannot cover, with stall length.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] i_op_id,
  input  logic [6:0] i_op_ex,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  output logic       o_hit,
  output logic [1:0] o_need
);
  logic w_m1;
  logic w_m2;

  assign w_m1 = reg_hit(i_rd, i_rs1);
  assign w_m2 = reg_hit(i_rd, i_rs2);

  // Store-data rs2 is forwarded M->EX, so only R-type rs2 counts for load-use.
  always_comb begin
    o_hit  = 1'b0;
    o_need = 2'd0;
    if (i_op_ex == OP_I_TYPE_LOAD && i_op_id == OP_B_TYPE && (w_m1 || w_m2)) begin
      o_hit  = 1'b1;
      o_need = 2'd2;
    end else if (i_op_ex == OP_I_TYPE_LOAD &&
                 ((w_m1 && (i_op_id == OP_R_TYPE || i_op_id == OP_I_TYPE_LOAD ||
                            i_op_id == OP_S_TYPE)) ||
                  (w_m2 && i_op_id == OP_R_TYPE))) begin
      o_hit  = 1'b1;
      o_need = 2'd1;
    end else if (i_op_ex == OP_R_TYPE && i_op_id == OP_B_TYPE && (w_m1 || w_m2)) begin
      o_hit  = 1'b1;
      o_need = 2'd1;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: hazard FSM, memory-wait freeze, stall and wait counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t           r_state;
  state_t           r_ret;
  logic [1:0]       r_hcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic             r_timeout;
  logic             w_hit;
  logic [1:0]       w_need;
  state_t           w_eff;
  ctrl_t            w_ctrl;

  hazard_detect u_detect (
    .i_op_id (bus.instr_ID[6:0]),
    .i_op_ex (bus.instr_EX[6:0]),
    .i_rs1   (bus.rs1_raddr_ID),
    .i_rs2   (bus.rs2_raddr_ID),
    .i_rd    (bus.rd_waddr_EX),
    .o_hit   (w_hit),
    .o_need  (w_need)
  );

  // After a memory wait the cycle is judged as if still in the state we left.
  assign w_eff = (r_state == ST_MEMWAIT) ? r_ret : r_state;

  always_comb begin
    w_ctrl = '0;
    if (bus.dmem_busy_M) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.stall_ex  = 1'b1;
      w_ctrl.stall_m   = 1'b1;
      w_ctrl.bubble_rb = 1'b1;
    end else if (w_eff == ST_HAZ || w_hit) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.bubble_ex = 1'b1;
    end
    w_ctrl.flush_id = bus.branch_taken_ID & ~w_ctrl.stall_id & ~bus.dmem_busy_M;
    if (!rst_n) w_ctrl = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_hcnt  <= 2'd0;
    end else if (bus.dmem_busy_M) begin
      r_state <= ST_MEMWAIT;
      if (r_state != ST_MEMWAIT) r_ret <= r_state;
    end else if (w_eff == ST_HAZ) begin
      r_hcnt  <= r_hcnt - 2'd1;
      r_state <= (r_hcnt == 2'd1) ? ST_RUN : ST_HAZ;
    end else if (w_hit) begin
      r_hcnt  <= w_need - 2'd1;
      r_state <= (w_need > 2'd1) ? ST_HAZ : ST_RUN;
    end else begin
      r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_ctrl.stall_if && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.dmem_busy_M) begin
        if (r_wait != WAIT_W'(MAX_WAIT)) r_wait <= r_wait + 1'b1;
        if (r_wait == WAIT_W'(MAX_WAIT - 1)) r_timeout <= 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign bus.stall_IF     = w_ctrl.stall_if;
  assign bus.stall_ID     = w_ctrl.stall_id;
  assign bus.stall_EX     = w_ctrl.stall_ex;
  assign bus.stall_M      = w_ctrl.stall_m;
  assign bus.bubble_EX    = w_ctrl.bubble_ex;
  assign bus.bubble_RB    = w_ctrl.bubble_rb;
  assign bus.flush_ID     = w_ctrl.flush_id;
  assign bus.stall_cycles = r_stall_cnt;
  assign bus.wait_timeout = r_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a remaining-stall-cycles reference model.
module tb_hazard_ctrl;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;
  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] NP = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int m_pend, m_stalls, m_wait;
  bit m_to;

  function automatic int model_need(input logic [6:0] oid, oex, input logic [4:0] a, b, d);
    bit m1, m2;
    m1 = (d != 0) && (d == a);
    m2 = (d != 0) && (d == b);
    if (oex == LD && oid == BR && (m1 || m2)) return 2;
    if (oex == LD && ((m1 && (oid == R || oid == LD || oid == ST)) || (m2 && oid == R))) return 1;
    if (oex == R && oid == BR && (m1 || m2)) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_M,
            bus.bubble_EX, bus.bubble_RB, bus.flush_ID};
  endfunction

  task automatic drive(input logic [6:0] oid, oex, input logic [4:0] a, b, d,
                       input logic bt, busy);
    bus.instr_ID        = {25'($urandom()), oid};
    bus.instr_EX        = {25'($urandom()), oex};
    bus.rs1_raddr_ID    = a;
    bus.rs2_raddr_ID    = b;
    bus.rd_waddr_EX     = d;
    bus.branch_taken_ID = bt;
    bus.dmem_busy_M     = busy;
    #3;
  endtask

  task automatic model_reset();
    m_pend = 0; m_stalls = 0; m_wait = 0; m_to = 1'b0;
  endtask

  // Checks the current cycle against the model, then advances one clock.
  task automatic cycle();
    logic [6:0] exp;
    int need;
    need = model_need(bus.instr_ID[6:0], bus.instr_EX[6:0], bus.rs1_raddr_ID,
                      bus.rs2_raddr_ID, bus.rd_waddr_EX);
    exp = 7'b0;
    if (bus.dmem_busy_M)  exp = 7'b1111010;
    else if (m_pend > 0)  exp = 7'b1100100;
    else if (need > 0)    exp = 7'b1100100;
    exp[0] = bus.branch_taken_ID && !exp[5] && !bus.dmem_busy_M;
    chk("ctrl", 32'(ctrl_vec()), 32'(exp));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
    chk("wait_timeout", 32'(bus.wait_timeout), 32'(m_to));
    if (exp[6] && m_stalls < (1 << CNT_W) - 1) m_stalls++;
    if (bus.dmem_busy_M) begin
      if (m_wait < MAX_WAIT) m_wait++;
      if (m_wait == MAX_WAIT) m_to = 1'b1;
    end else begin
      m_wait = 0;
      if (m_pend > 0) m_pend--;
      else if (need > 0) m_pend = need - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(LD, LD, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
    chk("rst_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("rst_timeout", 32'(bus.wait_timeout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    drive(NP, NP, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // 1: load-use, one stall cycle
    do_reset();
    drive(R, LD, 5, 7, 5, 0, 0);
    chk("t1_stall", 32'(ctrl_vec()), 32'b1100100);
    cycle();
    drive(R, NP, 5, 7, 0, 0, 0);
    chk("t1_release", 32'(ctrl_vec()), 32'd0);
    chk("t1_count", 32'(bus.stall_cycles), 32'd1);
    cycle();

    // 2: load->branch, two stall cycles
    do_reset();
    drive(BR, LD, 5, 0, 5, 0, 0);
    cycle();
    drive(BR, NP, 5, 0, 0, 0, 0);
    chk("t2_haz", 32'(ctrl_vec()), 32'b1100100);
    cycle();
    drive(BR, NP, 5, 0, 0, 0, 0);
    chk("t2_run", 32'(ctrl_vec()), 32'd0);
    chk("t2_count", 32'(bus.stall_cycles), 32'd2);
    cycle();

    // 3: store-data rs2 and rd=x0 give no stall
    drive(ST, LD, 8, 5, 5, 0, 0);
    chk("t3_store", 32'(ctrl_vec()), 32'd0);
    cycle();
    drive(R, LD, 0, 0, 0, 0, 0);
    chk("t3_x0", 32'(ctrl_vec()), 32'd0);
    cycle();

    // 4: memory wait during load->branch HAZ keeps hcnt
    do_reset();
    drive(BR, LD, 5, 0, 5, 0, 0);
    cycle();
    repeat (3) begin
      drive(BR, NP, 5, 0, 0, 1, 1);
      chk("t4_memwait", 32'(ctrl_vec()), 32'b1111010);
      cycle();
    end
    drive(BR, NP, 5, 0, 0, 0, 0);
    chk("t4_resume", 32'(ctrl_vec()), 32'b1100100);
    cycle();
    drive(BR, NP, 5, 0, 0, 0, 0);
    chk("t4_done", 32'(ctrl_vec()), 32'd0);
    chk("t4_count", 32'(bus.stall_cycles), 32'd5);
    cycle();

    // 5: flush, and flush suppressed by a hazard
    drive(BR, NP, 1, 2, 0, 1, 0);
    chk("t5_flush", 32'(bus.flush_ID), 32'd1);
    cycle();
    drive(R, LD, 3, 4, 4, 1, 0);
    chk("t5_noflush", 32'(bus.flush_ID), 32'd0);
    cycle();

    // 6: wait timeout and asynchronous reset mid-HAZ
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(NP, NP, 0, 0, 0, 0, 1);
      chk("t6_timeout", 32'(bus.wait_timeout), (k >= 4) ? 32'd1 : 32'd0);
      cycle();
    end
    drive(BR, LD, 5, 0, 5, 0, 0);
    chk("t6_sticky", 32'(bus.wait_timeout), 32'd1);
    cycle();
    drive(BR, LD, 5, 0, 5, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("t6_rst_count", 32'(bus.stall_cycles), 32'd0);
    chk("t6_rst_timeout", 32'(bus.wait_timeout), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic; small register range makes dependencies frequent.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [5];
      logic busy;
      ops = '{R, LD, ST, BR, NP};
      busy = ($urandom_range(0, 5) == 0) || (bus.dmem_busy_M && $urandom_range(0, 2) != 0);
      drive(ops[$urandom_range(0, 4)], ops[$urandom_range(0, 4)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), busy);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
